usb_rx_deserializer: RTL and testbench

Receive-side front end of the USB full/low-speed PHY path. Consumes one sampled differential line state per bit-time strobe from the upstream bit-timing counter, NRZI-decodes it, detects SYNC, removes stuffed bits, assembles LSB-first bytes and flags EOP. Feeds the downstream packet decoder with a byte stream plus active/valid/error/eop strobes.

---
 rtl/usb_pkg.sv | 40 ++++
 rtl/usb_nrzi_unstuff.sv | 56 +++++
 rtl/usb_rx_deserializer.sv | 200 ++++++++++++++++++++
 tb/tb_usb_rx_deserializer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_pkg
// Description : Shared types and helpers for the USB FS/LS receive front end.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_pkg;

  localparam int STUFF_LEN = 6;

  typedef enum logic [1:0] {
    LS_J   = 2'd0,
    LS_K   = 2'd1,
    LS_SE0 = 2'd2,
    LS_SE1 = 2'd3
  } line_state_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_DATA  = 3'd2,
    ST_EOP   = 3'd3,
    ST_ABORT = 3'd4
  } rx_state_e;

  // Low-speed links swap the J/K polarity; J is then the dm-high state.
  function automatic line_state_e decode_line(input logic dp, input logic dm,
                                              input logic low_speed);
    line_state_e ls;
    case ({dp, dm})
      2'b00:   ls = LS_SE0;
      2'b11:   ls = LS_SE1;
      2'b10:   ls = low_speed ? LS_K : LS_J;
      default: ls = low_speed ? LS_J : LS_K;
    endcase
    return ls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usb_nrzi_unstuff.sv
`default_nettype none
// ============================================================================
// Module      : usb_nrzi_unstuff
// Description : NRZI decoder and consecutive-ones tracker flagging stuffed bits.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_nrzi_unstuff
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_bit_valid,
  input  line_state_e i_line,
  input  logic        i_count_en,
  input  logic        i_count_clr,
  output logic        o_dec_bit,
  output logic        o_stuff_drop,
  output logic        o_stuff_err
);

  localparam logic [2:0] c_STUFF = 3'(STUFF_LEN);

  logic       r_prev_k;
  logic [2:0] r_ones;
  logic       w_is_jk;
  logic       w_full;

  assign w_is_jk      = (i_line == LS_J) || (i_line == LS_K);
  assign o_dec_bit    = ((i_line == LS_K) == r_prev_k);
  assign w_full       = (r_ones == c_STUFF);
  assign o_stuff_drop = i_count_en && w_is_jk && w_full && !o_dec_bit;
  assign o_stuff_err  = i_count_en && w_is_jk && w_full && o_dec_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_k <= 1'b0;
      r_ones   <= 3'd0;
    end else if (i_bit_valid) begin
      if (w_is_jk) begin
        r_prev_k <= (i_line == LS_K);
      end
      if (i_count_clr) begin
        r_ones <= 3'd0;
      end else if (i_count_en && w_is_jk) begin
        // A full run always ends here: either the stuffed 0 or an error.
        if (w_full || !o_dec_bit) begin
          r_ones <= 3'd0;
        end else begin
          r_ones <= r_ones + 3'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/usb_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : usb_rx_deserializer
// Description : USB FS/LS receive deserializer: SYNC, unstuff, bytes, EOP.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_rx_deserializer
  import usb_pkg::*;
#(
  parameter bit LOW_SPEED      = 1'b0,
  parameter int SYNC_MIN_ZEROS = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       bit_valid,
  input  logic       dp,
  input  logic       dm,
  output logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_error,
  output logic       eop
);

  localparam int              c_ZW   = $clog2(SYNC_MIN_ZEROS + 1) + 1;
  localparam logic [c_ZW-1:0] c_ZMIN = c_ZW'(SYNC_MIN_ZEROS);
  localparam logic [c_ZW-1:0] c_ZONE = c_ZW'(1);

  line_state_e     w_line;
  logic            w_dec_bit;
  logic            w_stuff_drop;
  logic            w_stuff_err;
  logic            w_enter_data;
  logic [7:0]      w_shifted;

  rx_state_e       r_state,      w_state_nxt;
  logic [c_ZW-1:0] r_zeros,      w_zeros_nxt;
  logic [7:0]      r_shreg,      w_shreg_nxt;
  logic [2:0]      r_bitcnt,     w_bitcnt_nxt;
  logic            r_misaligned, w_misaligned_nxt;
  logic            r_active,     w_active_nxt;
  logic [7:0]      r_data,       w_data_nxt;
  logic            r_valid,      w_valid_nxt;
  logic            r_error,      w_error_nxt;
  logic            r_eop,        w_eop_nxt;

  assign w_line    = decode_line(dp, dm, LOW_SPEED);
  assign w_shifted = {w_dec_bit, r_shreg[7:1]};

  usb_nrzi_unstuff u_nrzi_unstuff (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_bit_valid  (bit_valid),
    .i_line       (w_line),
    .i_count_en   (r_state == ST_DATA),
    .i_count_clr  (w_enter_data),
    .o_dec_bit    (w_dec_bit),
    .o_stuff_drop (w_stuff_drop),
    .o_stuff_err  (w_stuff_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_zeros_nxt      = r_zeros;
    w_shreg_nxt      = r_shreg;
    w_bitcnt_nxt     = r_bitcnt;
    w_misaligned_nxt = r_misaligned;
    w_active_nxt     = r_active;
    w_data_nxt       = r_data;
    w_valid_nxt      = 1'b0;
    w_error_nxt      = 1'b0;
    w_eop_nxt        = 1'b0;
    w_enter_data     = 1'b0;

    if (bit_valid) begin
      case (r_state)
        ST_IDLE: begin
          // The opening K is itself the first decoded 0 of SYNC.
          if (w_line == LS_K) begin
            w_state_nxt = ST_SYNC;
            w_zeros_nxt = (c_ZONE > c_ZMIN) ? c_ZMIN : c_ZONE;
          end
        end

        ST_SYNC: begin
          case (w_line)
            LS_J, LS_K: begin
              if (!w_dec_bit) begin
                if (r_zeros < c_ZMIN) begin
                  w_zeros_nxt = r_zeros + c_ZONE;
                end
              end else if (r_zeros >= c_ZMIN) begin
                w_state_nxt  = ST_DATA;
                w_active_nxt = 1'b1;
                w_bitcnt_nxt = 3'd0;
                w_enter_data = 1'b1;
              end else begin
                w_state_nxt = ST_IDLE;
              end
            end
            default: w_state_nxt = ST_IDLE;
          endcase
        end

        ST_DATA: begin
          case (w_line)
            LS_J, LS_K: begin
              if (w_stuff_err) begin
                w_error_nxt  = 1'b1;
                w_active_nxt = 1'b0;
                w_state_nxt  = ST_ABORT;
              end else if (!w_stuff_drop) begin
                w_shreg_nxt  = w_shifted;
                w_bitcnt_nxt = r_bitcnt + 3'd1;
                if (r_bitcnt == 3'd7) begin
                  w_data_nxt  = w_shifted;
                  w_valid_nxt = 1'b1;
                end
              end
            end
            LS_SE0: begin
              w_state_nxt      = ST_EOP;
              w_misaligned_nxt = (r_bitcnt != 3'd0);
            end
            default: begin
              w_error_nxt  = 1'b1;
              w_active_nxt = 1'b0;
              w_state_nxt  = ST_ABORT;
            end
          endcase
        end

        ST_EOP: begin
          case (w_line)
            LS_SE0: ;
            LS_J: begin
              w_active_nxt = 1'b0;
              w_state_nxt  = ST_IDLE;
              w_error_nxt  = r_misaligned;
              w_eop_nxt    = !r_misaligned;
            end
            default: begin
              w_error_nxt  = 1'b1;
              w_active_nxt = 1'b0;
              w_state_nxt  = ST_ABORT;
            end
          endcase
        end

        ST_ABORT: begin
          if (w_line == LS_J) begin
            w_state_nxt = ST_IDLE;
          end
        end

        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_zeros      <= '0;
      r_shreg      <= 8'h00;
      r_bitcnt     <= 3'd0;
      r_misaligned <= 1'b0;
      r_active     <= 1'b0;
      r_data       <= 8'h00;
      r_valid      <= 1'b0;
      r_error      <= 1'b0;
      r_eop        <= 1'b0;
    end else begin
      r_zeros      <= w_zeros_nxt;
      r_shreg      <= w_shreg_nxt;
      r_bitcnt     <= w_bitcnt_nxt;
      r_misaligned <= w_misaligned_nxt;
      r_active     <= w_active_nxt;
      r_data       <= w_data_nxt;
      r_valid      <= w_valid_nxt;
      r_error      <= w_error_nxt;
      r_eop        <= w_eop_nxt;
    end
  end

  assign rx_active = r_active;
  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign rx_error  = r_error;
  assign eop       = r_eop;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_rx_deserializer
// Description : Self-checking bench: packets are built by a bit-stuffing NRZI
//               encoder and the expected byte/eop/error stream by construction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_rx_deserializer;

  localparam int S_J = 0, S_K = 1, S_SE0 = 2, S_SE1 = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       bit_valid;
  logic       dp;
  logic       dm;
  logic       rx_active;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;
  logic       eop;

  usb_rx_deserializer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bit_valid (bit_valid),
    .dp        (dp),
    .dm        (dm),
    .rx_active (rx_active),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_error  (rx_error),
    .eop       (eop)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int syms[$];
  logic [7:0] expq[$];
  logic [7:0] gotq[$];
  int err_cnt = 0;
  int eop_cnt = 0;
  int both_cnt = 0;
  int eop_cyc = 0;
  int last_strobe = 0;
  int lvl;
  int ones;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation only; all comparisons live in the test tasks.
  always @(negedge clk) begin
    if (rx_valid) gotq.push_back(rx_data);
    if (rx_error) err_cnt++;
    if (eop) begin
      eop_cnt++;
      eop_cyc = cyc;
    end
    if (rx_error && eop) both_cnt++;
  end

  task automatic clear_mon();
    gotq = {};
    expq = {};
    err_cnt = 0;
    eop_cnt = 0;
  endtask

  task automatic drive_sym(input int s);
    case (s)
      S_J:     {dp, dm} = 2'b10;
      S_K:     {dp, dm} = 2'b01;
      S_SE0:   {dp, dm} = 2'b00;
      default: {dp, dm} = 2'b11;
    endcase
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_sym(input int s, input int gap);
    drive_sym(s);
    bit_valid = 1'b1;
    last_strobe = cyc + 1;
    @(posedge clk);
    #1;
    if (gap > 0) idle(gap);
  endtask

  task automatic play_range(input int lo, input int hi, input int gap);
    for (int i = lo; i < hi; i++) send_sym(syms[i], gap);
  endtask

  task automatic play(input int gap);
    play_range(0, syms.size(), gap);
    idle(4);
  endtask

  task automatic start_pkt();
    syms = {};
    syms.push_back(S_J);
    syms.push_back(S_J);
    for (int i = 0; i < 6; i++) syms.push_back((i % 2 == 0) ? S_K : S_J);
    syms.push_back(S_K);
    syms.push_back(S_K);
    lvl = S_K;
    ones = 0;
  endtask

  // USB encoding: 0 toggles the line, 1 holds it; a 0 follows every six 1s.
  task automatic add_bit(input bit b);
    if (!b) lvl = (lvl == S_J) ? S_K : S_J;
    syms.push_back(lvl);
    if (b) begin
      ones++;
      if (ones == 6) begin
        lvl = (lvl == S_J) ? S_K : S_J;
        syms.push_back(lvl);
        ones = 0;
      end
    end else begin
      ones = 0;
    end
  endtask

  task automatic add_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) add_bit(v[i]);
    expq.push_back(v);
  endtask

  task automatic add_eop();
    syms.push_back(S_SE0);
    syms.push_back(S_SE0);
    syms.push_back(S_J);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bit_valid = 1'b0;
    dp = 1'b1;
    dm = 1'b0;
    idle(3);
    total_cnt++;
    if ({rx_active, rx_valid, rx_error, eop} !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", {rx_active, rx_valid, rx_error, eop});
    else pass_cnt++;
    total_cnt++;
    if (rx_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", rx_data);
    else pass_cnt++;
    reset_n = 1'b1;
    idle(3);
    total_cnt++;
    if ({rx_active, rx_data, rx_valid, rx_error, eop} !== 12'h000) $display("FAIL post_reset_idle: got %h expected 000", {rx_active, rx_data, rx_valid, rx_error, eop});
    else pass_cnt++;
  endtask

  task automatic test_pid_a5();
    clear_mon();
    start_pkt();
    add_byte(8'hA5);
    add_eop();
    play_range(0, 9, 0);
    total_cnt++;
    if (rx_active !== 1'b0) $display("FAIL sync_early_active: got %b expected 0", rx_active);
    else pass_cnt++;
    play_range(9, 10, 0);
    total_cnt++;
    if (rx_active !== 1'b1) $display("FAIL sync_active: got %b expected 1", rx_active);
    else pass_cnt++;
    play_range(10, syms.size(), 0);
    idle(4);
    total_cnt++;
    if (gotq.size() != 1) $display("FAIL pid_count: got %0d expected 1", gotq.size());
    else pass_cnt++;
    total_cnt++;
    if (gotq.size() < 1 || gotq[0] !== 8'hA5) $display("FAIL pid_data: got %h expected a5", (gotq.size() > 0) ? gotq[0] : 8'hxx);
    else pass_cnt++;
    total_cnt++;
    if (eop_cnt != 1 || err_cnt != 0) $display("FAIL pid_eop: got eop=%0d err=%0d expected eop=1 err=0", eop_cnt, err_cnt);
    else pass_cnt++;
    total_cnt++;
    if (eop_cyc != last_strobe) $display("FAIL pid_eop_latency: got cycle %0d expected %0d", eop_cyc, last_strobe);
    else pass_cnt++;
    total_cnt++;
    if (rx_active !== 1'b0) $display("FAIL pid_active_end: got %b expected 0", rx_active);
    else pass_cnt++;
  endtask

  task automatic test_stuffing();
    clear_mon();
    start_pkt();
    add_byte(8'hFF);
    add_byte(8'hFF);
    add_eop();
    play(0);
    total_cnt++;
    if (gotq.size() != 2) $display("FAIL stuff_count: got %0d expected 2", gotq.size());
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (i >= gotq.size() || gotq[i] !== 8'hFF) $display("FAIL stuff_data[%0d]: got %h expected ff", i, (i < gotq.size()) ? gotq[i] : 8'hxx);
      else pass_cnt++;
    end
    total_cnt++;
    if (eop_cnt != 1 || err_cnt != 0) $display("FAIL stuff_eop: got eop=%0d err=%0d expected eop=1 err=0", eop_cnt, err_cnt);
    else pass_cnt++;
  endtask

  task automatic test_random_packets(input string name, input int npkt);
    for (int p = 0; p < npkt; p++) begin
      int gap;
      int n;
      gap = $urandom_range(0, 3);
      n = $urandom_range(1, 4);
      clear_mon();
      start_pkt();
      for (int b = 0; b < n; b++) add_byte(8'($urandom));
      add_eop();
      play(gap);
      total_cnt++;
      if (gotq.size() != expq.size()) $display("FAIL %s_count[%0d]: got %0d expected %0d", name, p, gotq.size(), expq.size());
      else pass_cnt++;
      for (int i = 0; i < expq.size(); i++) begin
        total_cnt++;
        if (i >= gotq.size() || gotq[i] !== expq[i]) $display("FAIL %s_data[%0d][%0d]: got %h expected %h", name, p, i, (i < gotq.size()) ? gotq[i] : 8'hxx, expq[i]);
        else pass_cnt++;
      end
      total_cnt++;
      if (eop_cnt != 1 || err_cnt != 0) $display("FAIL %s_eop[%0d]: got eop=%0d err=%0d expected eop=1 err=0", name, p, eop_cnt, err_cnt);
      else pass_cnt++;
    end
  endtask

  task automatic test_stuff_error();
    clear_mon();
    start_pkt();
    for (int i = 0; i < 7; i++) syms.push_back(S_K);
    syms.push_back(S_J);
    play(0);
    total_cnt++;
    if (gotq.size() != 0) $display("FAIL stufferr_valid: got %0d expected 0", gotq.size());
    else pass_cnt++;
    total_cnt++;
    if (err_cnt != 1 || eop_cnt != 0) $display("FAIL stufferr_err: got err=%0d eop=%0d expected err=1 eop=0", err_cnt, eop_cnt);
    else pass_cnt++;
    total_cnt++;
    if (rx_active !== 1'b0) $display("FAIL stufferr_active: got %b expected 0", rx_active);
    else pass_cnt++;
    test_random_packets("after_stufferr", 1);
  endtask

  task automatic test_unaligned_eop();
    clear_mon();
    start_pkt();
    add_byte(8'hA5);
    for (int i = 0; i < 3; i++) add_bit(1'($urandom));
    add_eop();
    play(1);
    total_cnt++;
    if (gotq.size() != 1 || gotq[0] !== 8'hA5) $display("FAIL unaligned_data: got count=%0d first=%h expected count=1 first=a5", gotq.size(), (gotq.size() > 0) ? gotq[0] : 8'hxx);
    else pass_cnt++;
    total_cnt++;
    if (err_cnt != 1 || eop_cnt != 0) $display("FAIL unaligned_err: got err=%0d eop=%0d expected err=1 eop=0", err_cnt, eop_cnt);
    else pass_cnt++;
  endtask

  task automatic test_se1_abort();
    clear_mon();
    start_pkt();
    add_byte(8'($urandom));
    syms.push_back(S_SE1);
    syms.push_back(S_J);
    play(0);
    total_cnt++;
    if (gotq.size() != 1 || gotq[0] !== expq[0]) $display("FAIL se1_data: got count=%0d first=%h expected count=1 first=%h", gotq.size(), (gotq.size() > 0) ? gotq[0] : 8'hxx, expq[0]);
    else pass_cnt++;
    total_cnt++;
    if (err_cnt != 1 || eop_cnt != 0 || rx_active !== 1'b0) $display("FAIL se1_err: got err=%0d eop=%0d active=%b expected err=1 eop=0 active=0", err_cnt, eop_cnt, rx_active);
    else pass_cnt++;
  endtask

  task automatic test_gap();
    logic [7:0] pkt [3];
    for (int i = 0; i < 3; i++) pkt[i] = 8'($urandom);
    for (int k = 0; k < 2; k++) begin
      clear_mon();
      start_pkt();
      for (int i = 0; i < 3; i++) add_byte(pkt[i]);
      add_eop();
      play((k == 0) ? 0 : 3);
      total_cnt++;
      if (gotq.size() != 3) $display("FAIL gap%0d_count: got %0d expected 3", k, gotq.size());
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
        total_cnt++;
        if (i >= gotq.size() || gotq[i] !== pkt[i]) $display("FAIL gap%0d_data[%0d]: got %h expected %h", k, i, (i < gotq.size()) ? gotq[i] : 8'hxx, pkt[i]);
        else pass_cnt++;
      end
      total_cnt++;
      if (eop_cnt != 1 || err_cnt != 0) $display("FAIL gap%0d_eop: got eop=%0d err=%0d expected eop=1 err=0", k, eop_cnt, err_cnt);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    start_pkt();
    add_byte(8'hA5);
    for (int i = 0; i < 4; i++) add_bit(1'($urandom));
    play_range(0, syms.size(), 0);
    total_cnt++;
    if (rx_active !== 1'b1 || rx_data !== 8'hA5) $display("FAIL midreset_pre: got active=%b data=%h expected active=1 data=a5", rx_active, rx_data);
    else pass_cnt++;
    bit_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({rx_active, rx_data, rx_valid, rx_error, eop} !== 12'h000) $display("FAIL midreset_clear: got %h expected 000", {rx_active, rx_data, rx_valid, rx_error, eop});
    else pass_cnt++;
    idle(2);
    reset_n = 1'b1;
    idle(4);
    total_cnt++;
    if (err_cnt != 0 || eop_cnt != 0) $display("FAIL midreset_pulses: got err=%0d eop=%0d expected 0 0", err_cnt, eop_cnt);
    else pass_cnt++;
    test_random_packets("after_reset", 1);
  endtask

  initial begin
    test_reset();
    test_pid_a5();
    test_stuffing();
    test_stuff_error();
    test_unaligned_eop();
    test_se1_abort();
    test_gap();
    test_random_packets("random", 8);
    test_reset_mid();
    total_cnt++;
    if (both_cnt != 0) $display("FAIL err_eop_overlap: got %0d cycles expected 0", both_cnt);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
